// File: rtl/ysyx_22041412_ifu.sv
// ysyx_22041412_ifu -- instruction fetch unit.
//
// Keeps the PC and issues one word fetch at a time. Returned words are
// buffered as {instr, pc} entries in a small FIFO that feeds decode.
// A redirect retargets the PC, flushes the FIFO and discards any response
// that is still in flight.
//
// Ports:
//   clk, rst_n        clock (rising edge) / async active-low reset
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_rsp_*        fetch response (one per accepted request)
//   id_*              FIFO head to decode (valid/ready, instr, pc)
//   redirect_*        PC retarget from decode/execute (bits [31:0] used)
//   fifo_count        buffer occupancy (debug)
module ysyx_22041412_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [31:0]                 imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [31:0]                 imem_rsp_data,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [31:0]                 id_instr,
  output logic [31:0]                 id_pc,
  input  logic                        redirect_valid,
  input  logic [63:0]                 redirect_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  state_t        state, state_n;
  logic [31:0]   pc, req_pc;
  fetch_ent_t    buf_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          not_full, req_fire, push, pop;
  logic          unused_hi;

  assign unused_hi = ^redirect_pc[63:32];

  assign not_full = count < DEPTH_C;

  // Issue only when the FIFO has room for the word, so count plus the
  // single outstanding request never exceeds FIFO_DEPTH. Valid is also held
  // low during a redirect so the address never changes under a live request.
  always_comb begin
    state_n        = state;
    imem_req_valid = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = rst_n & not_full & ~redirect_valid;
        if (imem_req_valid & imem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)      state_n = imem_rsp_valid ? S_REQ : S_DROP;
        else if (imem_rsp_valid) state_n = S_REQ;
      end
      S_DROP: begin
        if (imem_rsp_valid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid & imem_req_ready;
  assign push          = (state == S_WAIT) & imem_rsp_valid & ~redirect_valid;
  assign pop           = id_valid & id_ready & ~redirect_valid;

  assign id_valid   = count != '0;
  assign id_instr   = id_valid ? buf_q[rd_ptr].instr : '0;
  assign id_pc      = id_valid ? buf_q[rd_ptr].pc    : '0;
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) pc <= redirect_pc[31:0];
      else if (req_fire)  pc <= pc + 32'd4;
      if (req_fire) req_pc <= pc;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        // push+pop together leaves count unchanged, even when full
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage needs no reset: the head is masked by count.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= '{instr: imem_rsp_data, pc: req_pc};
  end

  // Issue gating makes a push into a full FIFO without a pop impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (not_full || pop));

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
module tb_ysyx_22041412_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 2;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  fifo_count;

  ysyx_22041412_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  int nvec = 0;
  int nerr = 0;

  // per-cycle stimulus knobs
  bit          r_ready, r_idr, r_redir;
  logic [31:0] r_rpc;
  int          r_lat;

  // reference model: expected buffer contents, next fetch PC, outstanding
  // request status (0 none, 1 live, 2 to be discarded)
  ent_t        q[$];
  logic [31:0] mpc, out_pc;
  int          out;

  // memory responder
  bit          pend;
  int          lat;
  logic [31:0] pend_data;

  logic [31:0] fired[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fired_at(input int i);
    if (fired.size() > i) return fired[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    logic        exp_rv, fire;
    logic [31:0] ei, ep;
    ent_t        e;
    @(negedge clk);
    imem_req_ready = r_ready;
    id_ready       = r_idr;
    redirect_valid = r_redir;
    redirect_pc    = {$urandom, r_rpc};
    if (pend && lat == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = (out == 0) && (q.size() < DEPTH) && !r_redir;
    if (q.size() != 0) begin ei = q[0].instr; ep = q[0].pc; end
    else begin ei = '0; ep = '0; end
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, mpc);
    chk("id_valid", 32'(id_valid), 32'(q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("id_instr", id_instr, ei);
    chk("id_pc", id_pc, ep);
    if (imem_req_valid && imem_req_ready) fired.push_back(imem_req_addr);
    // model update for this edge
    fire = exp_rv && r_ready;
    if (r_redir) begin
      mpc = r_rpc;
      q.delete();
      if (out != 0) out = imem_rsp_valid ? 0 : 2;
    end else begin
      if (q.size() != 0 && r_idr) void'(q.pop_front());
      if (out != 0 && imem_rsp_valid) begin
        if (out == 1) begin
          e.instr = imem_rsp_data;
          e.pc    = out_pc;
          q.push_back(e);
        end
        out = 0;
      end
      if (fire) begin
        out    = 1;
        out_pc = mpc;
        mpc    = mpc + 32'd4;
      end
    end
    // responder: answers every accepted request after r_lat+1 cycles
    if (imem_rsp_valid) pend = 1'b0;
    else if (pend) lat--;
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      lat       = r_lat;
      pend_data = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    r_redir        = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    q.delete();
    mpc  = RST_PC;
    out  = 0;
    pend = 1'b0;
    lat  = 0;
    fired.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tmp;
    rst_n = 1'b0;
    r_ready = 1'b0; r_idr = 1'b0; r_redir = 1'b0; r_rpc = '0; r_lat = 0;

    // 1: streaming fetch
    do_reset();
    r_ready = 1; r_idr = 1; r_lat = 0;
    repeat (10) tick();
    chk("t1_addr0", fired_at(0), 32'h8000_0000);
    chk("t1_addr1", fired_at(1), 32'h8000_0004);
    chk("t1_addr2", fired_at(2), 32'h8000_0008);

    // 2: decode stalled, buffer fills, then drains
    do_reset();
    r_ready = 1; r_idr = 0; r_lat = 0;
    repeat (8) tick();
    chk("t2_count", 32'(fifo_count), 32'd2);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_nfired", 32'(fired.size()), 32'd2);
    r_idr = 1;
    repeat (6) tick();
    chk("t2_resume", fired_at(2), 32'h8000_0008);

    // 3: redirect while waiting, slow response discarded
    do_reset();
    r_ready = 1; r_idr = 1; r_lat = 3;
    tick();
    r_redir = 1; r_rpc = 32'h8000_0100;
    tick();
    r_redir = 0;
    chk("t3_count", 32'(fifo_count), 32'd0);
    chk("t3_id_valid", 32'(id_valid), 32'd0);
    repeat (8) tick();
    chk("t3_addr0", fired_at(0), 32'h8000_0000);
    chk("t3_addr1", fired_at(1), 32'h8000_0100);

    // 4: redirect together with response and pop, one entry buffered
    do_reset();
    r_ready = 1; r_idr = 0; r_lat = 0;
    repeat (3) tick();
    r_idr = 1; r_redir = 1; r_rpc = 32'h8000_0100;
    tick();
    r_redir = 0;
    chk("t4_count", 32'(fifo_count), 32'd0);
    chk("t4_id_valid", 32'(id_valid), 32'd0);
    repeat (2) tick();
    chk("t4_addr2", fired_at(2), 32'h8000_0100);

    // 5: two redirects while discarding
    do_reset();
    r_ready = 1; r_idr = 1; r_lat = 5;
    tick();
    r_redir = 1; r_rpc = 32'h8000_0200;
    tick();
    r_rpc = 32'h8000_0300;
    tick();
    r_redir = 0;
    repeat (10) tick();
    chk("t5_addr1", fired_at(1), 32'h8000_0300);

    // 6: reset mid-wait with one entry buffered
    do_reset();
    r_ready = 1; r_idr = 0; r_lat = 0;
    repeat (2) tick();
    r_lat = 4;
    tick();
    chk("t6_pre_count", 32'(fifo_count), 32'd1);
    #2;
    do_reset();
    r_ready = 1; r_idr = 1; r_lat = 0;
    repeat (2) tick();
    chk("t6_addr0", fired_at(0), 32'h8000_0000);

    // 7: PC wraps at the top of the address space
    do_reset();
    r_ready = 1; r_idr = 1; r_lat = 0;
    r_redir = 1; r_rpc = 32'hFFFF_FFFC;
    tick();
    r_redir = 0;
    repeat (6) tick();
    chk("t7_addr0", fired_at(0), 32'hFFFF_FFFC);
    chk("t7_addr1", fired_at(1), 32'h0000_0000);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r_ready = ($urandom % 4) != 0;
      r_idr   = ($urandom % 3) != 0;
      r_lat   = $urandom_range(0, 3);
      r_redir = ($urandom % 12) == 0;
      tmp     = $urandom;
      r_rpc   = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : {tmp[31:2], 2'b00};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_ifu.md
Name: ysyx_22041412_ifu

Overview:
Instruction fetch unit that produces the {instr, pc} stream consumed by the decode stage. It keeps the PC and issues one word-fetch at a time over a valid/ready request channel to instruction memory. It buffers returned words in a small FIFO presented to decode with valid/ready. A redirect from decode (early JAL) or execute (branch/JALR) retargets the PC, flushes the FIFO and discards any in-flight response.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded at reset.
FIFO_DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address, word aligned
imem_rsp_valid  input  1  read data valid (one per accepted request, ≥1 cycle after acceptance)
imem_rsp_data  input  32  instruction word
id_valid  output  1  FIFO head valid to decode
id_ready  input  1  decode consumes head
id_instr  output  32  head instruction
id_pc  output  32  head PC
redirect_valid  input  1  PC redirect (jal_ok or execute branch taken)
redirect_pc  input  64  new PC; bits [31:0] used, [1:0] must be 00
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy, debug

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=REQ, FIFO empty, imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0, fifo_count=0.
- States: REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to discard).
- REQ: imem_req_valid = (fifo_count < FIFO_DEPTH) & ~redirect_valid; imem_req_addr=pc. On valid&ready: latch req_pc=pc, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), go WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: push {imem_rsp_data, req_pc}, go REQ.
- DROP: imem_req_valid=0. On imem_rsp_valid: discard data, go REQ.
- Redirect (highest priority, any state): pc<=redirect_pc[31:0]; FIFO flushed (count=0, pointers reset); push suppressed; pop ignored.
  - In REQ with no handshake: stay REQ; imem_req_valid forced 0 this cycle, so the address change is never seen mid-request.
  - In WAIT without rsp_valid: go DROP. In WAIT with rsp_valid same cycle: response discarded, go REQ.
  - In DROP: stay DROP (pc updated again) unless rsp_valid same cycle, then go REQ.
- FIFO: id_valid = count!=0; id_instr/id_pc = head entry (0 when empty). Pop on id_valid&id_ready. Simultaneous push and pop: count unchanged, allowed even when full (push only occurs if space was checked at issue; pops only free space). No push when full ever occurs by construction; assert in sim.
- Issue gating guarantees count + outstanding ≤ FIFO_DEPTH.
- Throughput: best case one instruction per 2 cycles (REQ/WAIT alternate). Redirect-to-first-request latency: 1 cycle (from REQ).
- Pointer wrap modulo FIFO_DEPTH; count saturates never (gating).

Test Plan:
1. Reset release, imem always ready, rsp 1 cycle after accept, id_ready=1 -> request addrs 8000_0000, 8000_0004, 8000_0008…; id_pc matches addr of each returned word, id_instr equals returned data.
2. id_ready=0, stream responses -> exactly 2 entries buffered, fifo_count=2, imem_req_valid stays 0; raise id_ready -> entries drain in order, fetch resumes at 8000_0008.
3. Redirect to 8000_0100 while in WAIT, response arrives 3 cycles later -> response discarded, fifo_count=0, next request addr 8000_0100, no stale id_valid.
4. Redirect coincident with rsp_valid and with pop, FIFO holding 1 entry -> FIFO empty next cycle, data dropped, next request 8000_0100.
5. Two redirects during DROP (8000_0200 then 8000_0300) -> single discard, next request addr 8000_0300.
6. Assert rst_n low mid-WAIT with FIFO at 1 -> immediately id_valid=0, imem_req_valid=0, fifo_count=0; after release first request addr 8000_0000.
